// File: rtl/interval_timer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : interval_timer_ctrl
// Description : Programmable interval timer for the traffic-light sequencer.
//               Optional pause input enabled by defining TIMER_PAUSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module interval_timer_ctrl #(
    parameter int CNT_W    = 4,
    parameter int TICK_DIV = 1000,
    parameter int DEF_BASE = 6,
    parameter int DEF_EXT  = 3,
    parameter int DEF_YEL  = 2
) (
    input  logic             clk,
    input  logic             g_reset,
    input  logic             prog_sync,
    input  logic [1:0]       param_sel,
    input  logic [CNT_W-1:0] time_value,
    input  logic             start_timer,
    input  logic [1:0]       interval,
`ifdef TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic             expired,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic             one_hz
);

    localparam int               DIV_W      = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] C_DEF_BASE = CNT_W'(DEF_BASE);
    localparam logic [CNT_W-1:0] C_DEF_EXT  = CNT_W'(DEF_EXT);
    localparam logic [CNT_W-1:0] C_DEF_YEL  = CNT_W'(DEF_YEL);
    localparam logic [1:0]       SEL_BASE   = 2'b00;
    localparam logic [1:0]       SEL_EXT    = 2'b01;
    localparam logic [1:0]       SEL_YEL    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic             start_q, start_d;
    logic             pend_q,  pend_d;
    logic [1:0]       int_q,   int_d;
    logic [CNT_W-1:0] base_q,  base_d;
    logic [CNT_W-1:0] ext_q,   ext_d;
    logic [CNT_W-1:0] yel_q,   yel_d;

    logic             w_run;
    logic             w_start;
    logic             w_tick;
    logic             w_load;
    logic [1:0]       w_load_code;
    logic [CNT_W-1:0] w_load_val;

    function automatic logic [CNT_W-1:0] pick_dur(
        input logic [1:0]       code,
        input logic [CNT_W-1:0] b,
        input logic [CNT_W-1:0] e,
        input logic [CNT_W-1:0] y
    );
        case (code)
            SEL_BASE: pick_dur = b;
            SEL_EXT:  pick_dur = e;
            SEL_YEL:  pick_dur = y;
            default:  pick_dur = '0;
        endcase
    endfunction

`ifdef TIMER_PAUSE_EN
    assign w_run = ~pause;
`else
    assign w_run = 1'b1;
`endif

    assign w_start = start_timer & ~start_q;
    assign w_tick  = w_run & (div_q == C_DIV_LAST);

    // A start caught during DONE is replayed from int_q on the following IDLE cycle.
    assign w_load      = ((state_q == ST_IDLE) && (w_start || pend_q)) ||
                         ((state_q == ST_COUNT) && w_start);
    assign w_load_code = w_start ? interval : int_q;
    assign w_load_val  = pick_dur(w_load_code, base_q, ext_q, yel_q);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        div_d   = div_q;
        start_d = start_timer;
        pend_d  = pend_q;
        int_d   = int_q;
        base_d  = base_q;
        ext_d   = ext_q;
        yel_d   = yel_q;

        if (w_run) begin
            div_d = w_tick ? '0 : div_q + DIV_W'(1);
        end

        // Zero durations are refused so every programmed interval is non-empty.
        if (prog_sync && (time_value != '0)) begin
            case (param_sel)
                SEL_BASE: base_d = time_value;
                SEL_EXT:  ext_d  = time_value;
                SEL_YEL:  yel_d  = time_value;
                default:  ;
            endcase
        end

        case (state_q)
            ST_IDLE, ST_COUNT: begin
                if (w_load) begin
                    int_d   = w_load_code;
                    pend_d  = 1'b0;
                    div_d   = '0;
                    rem_d   = w_load_val;
                    state_d = (w_load_val != '0) ? ST_COUNT : ST_DONE;
                end else if ((state_q == ST_COUNT) && w_tick) begin
                    if (rem_q <= CNT_W'(1)) begin
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                rem_d   = '0;
                state_d = ST_IDLE;
                if (w_start) begin
                    pend_d = 1'b1;
                    int_d  = interval;
                    div_d  = '0;
                end
            end
            default: begin
                rem_d   = '0;
                pend_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            div_q   <= '0;
            start_q <= 1'b0;
            pend_q  <= 1'b0;
            int_q   <= 2'b00;
            base_q  <= C_DEF_BASE;
            ext_q   <= C_DEF_EXT;
            yel_q   <= C_DEF_YEL;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            start_q <= start_d;
            pend_q  <= pend_d;
            int_q   <= int_d;
            base_q  <= base_d;
            ext_q   <= ext_d;
            yel_q   <= yel_d;
        end
    end

    assign expired   = (state_q == ST_DONE);
    assign busy      = (state_q == ST_COUNT);
    assign remaining = rem_q;
    assign one_hz    = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_interval_timer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_interval_timer_ctrl
// Description : Directed self-checking bench for interval_timer_ctrl, TICK_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_interval_timer_ctrl;

    localparam int CNT_W    = 4;
    localparam int TICK_DIV = 4;

    logic             clk = 1'b0;
    logic             g_reset = 1'b1;
    logic             prog_sync = 1'b0;
    logic [1:0]       param_sel = 2'b00;
    logic [CNT_W-1:0] time_value = '0;
    logic             start_timer = 1'b0;
    logic [1:0]       interval = 2'b00;
`ifdef TIMER_PAUSE_EN
    logic             pause = 1'b0;
`endif
    logic             expired;
    logic             busy;
    logic [CNT_W-1:0] remaining;
    logic             one_hz;

    int n_tests = 0;
    int n_fail  = 0;

    interval_timer_ctrl #(
        .CNT_W    (CNT_W),
        .TICK_DIV (TICK_DIV),
        .DEF_BASE (6),
        .DEF_EXT  (3),
        .DEF_YEL  (2)
    ) dut (
        .clk         (clk),
        .g_reset     (g_reset),
        .prog_sync   (prog_sync),
        .param_sel   (param_sel),
        .time_value  (time_value),
        .start_timer (start_timer),
        .interval    (interval),
`ifdef TIMER_PAUSE_EN
        .pause       (pause),
`endif
        .expired     (expired),
        .busy        (busy),
        .remaining   (remaining),
        .one_hz      (one_hz)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges counted from now until expired is seen; -1 when the bound runs out.
    task automatic wait_exp(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (expired) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic start_code(input logic [1:0] code);
        start_timer = 1'b1;
        interval    = code;
        tick();
        start_timer = 1'b0;
    endtask

    task automatic program_reg(input logic [1:0] sel, input logic [CNT_W-1:0] val);
        prog_sync  = 1'b1;
        param_sel  = sel;
        time_value = val;
        tick();
        prog_sync  = 1'b0;
    endtask

    task automatic test_reset();
        g_reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({expired, busy, remaining, one_hz} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got exp=%b busy=%b rem=%0d hz=%b expected all 0",
                     expired, busy, remaining, one_hz);
        end
        g_reset = 1'b0;
        tick();
    endtask

    task automatic test_base_default();
        int seq[$];
        int n, hz;
        logic [CNT_W-1:0] last;
        logic busy_at_exp;
        start_code(2'b00);
        n_tests++;
        if (remaining !== 4'd6 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL base_load: got rem=%0d busy=%b expected rem=6 busy=1", remaining, busy);
        end
        seq.push_back(int'(remaining));
        last = remaining;
        n = -1;
        hz = 0;
        busy_at_exp = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (one_hz && !expired) hz++;
            if (remaining != last) begin
                seq.push_back(int'(remaining));
                last = remaining;
            end
            if (expired) begin
                n = i;
                busy_at_exp = busy;
                break;
            end
        end
        n_tests++;
        if (n < 23 || n > 25) begin
            n_fail++;
            $display("FAIL base_latency: got %0d cycles expected 24 +/- 1", n);
        end
        n_tests++;
        if (hz != 6) begin
            n_fail++;
            $display("FAIL base_one_hz_count: got %0d pulses expected 6", hz);
        end
        n_tests++;
        if (seq.size() != 7 || seq[0] != 6 || seq[1] != 5 || seq[2] != 4 || seq[3] != 3 ||
            seq[4] != 2 || seq[5] != 1 || seq[6] != 0) begin
            n_fail++;
            $display("FAIL base_rem_seq: got %p expected 6,5,4,3,2,1,0", seq);
        end
        n_tests++;
        if (busy_at_exp !== 1'b0) begin
            n_fail++;
            $display("FAIL base_busy_at_expired: got %b expected 0", busy_at_exp);
        end
        tick();
        n_tests++;
        if (expired !== 1'b0 || remaining !== 4'd0) begin
            n_fail++;
            $display("FAIL base_expired_width: got exp=%b rem=%0d expected exp=0 rem=0",
                     expired, remaining);
        end
    endtask

    task automatic test_tzero();
        start_code(2'b11);
        n_tests++;
        if (expired !== 1'b1 || busy !== 1'b0 || remaining !== 4'd0) begin
            n_fail++;
            $display("FAIL tzero_pulse: got exp=%b busy=%b rem=%0d expected exp=1 busy=0 rem=0",
                     expired, busy, remaining);
        end
        tick();
        n_tests++;
        if (expired !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tzero_after: got exp=%b busy=%b expected exp=0 busy=0", expired, busy);
        end
    endtask

    task automatic test_programming();
        int n;
        program_reg(2'b10, 4'd5);
        start_code(2'b10);
        n_tests++;
        if (remaining !== 4'd5) begin
            n_fail++;
            $display("FAIL prog_yel_load: got %0d expected 5", remaining);
        end
        wait_exp(40, n);
        n_tests++;
        if (n < 19 || n > 21) begin
            n_fail++;
            $display("FAIL prog_yel_latency: got %0d cycles expected 20 +/- 1", n);
        end
        tick();
        program_reg(2'b01, 4'd0);
        start_code(2'b01);
        n_tests++;
        if (remaining !== 4'd3) begin
            n_fail++;
            $display("FAIL prog_ext_zero_rejected: got %0d expected 3", remaining);
        end
        wait_exp(40, n);
        tick();
        program_reg(2'b11, 4'd9);
        start_code(2'b00);
        n_tests++;
        if (remaining !== 4'd6) begin
            n_fail++;
            $display("FAIL prog_reserved_ignored: got base %0d expected 6", remaining);
        end
        wait_exp(40, n);
        tick();
    endtask

    task automatic test_restart();
        int n, extra;
        logic early;
        start_code(2'b00);
        early = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (expired) early = 1'b1;
        end
        start_code(2'b01);
        n_tests++;
        if (remaining !== 4'd3 || busy !== 1'b1 || early !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_load: got rem=%0d busy=%b early=%b expected rem=3 busy=1 early=0",
                     remaining, busy, early);
        end
        wait_exp(40, n);
        n_tests++;
        if (n < 11 || n > 13) begin
            n_fail++;
            $display("FAIL restart_latency: got %0d cycles expected 12 +/- 1", n);
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (expired) extra++;
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL restart_single_expire: got %0d extra pulses expected 0", extra);
        end
    endtask

    task automatic test_collision();
        int n;
        prog_sync   = 1'b1;
        param_sel   = 2'b00;
        time_value  = 4'd9;
        start_code(2'b00);
        prog_sync   = 1'b0;
        n_tests++;
        if (remaining !== 4'd6) begin
            n_fail++;
            $display("FAIL collision_prewrite: got %0d expected 6", remaining);
        end
        wait_exp(40, n);
        n_tests++;
        if (n < 23 || n > 25) begin
            n_fail++;
            $display("FAIL collision_latency: got %0d cycles expected 24 +/- 1", n);
        end
        tick();
        start_code(2'b00);
        n_tests++;
        if (remaining !== 4'd9) begin
            n_fail++;
            $display("FAIL collision_new_base: got %0d expected 9", remaining);
        end
    endtask

    // Continues the 9-second base count left running by test_collision.
    task automatic test_async_reset();
        int n, pulses;
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (remaining == 4'd3) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL areset_reach_rem3: got rem=%0d expected 3", remaining);
        end
        #2;
        g_reset = 1'b1;
        #1;
        n_tests++;
        if ({expired, busy, remaining, one_hz} !== 7'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: got exp=%b busy=%b rem=%0d hz=%b expected all 0",
                     expired, busy, remaining, one_hz);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (expired) pulses++;
        end
        g_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (expired) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL areset_no_expire: got %0d pulses expected 0", pulses);
        end
        start_code(2'b00);
        n_tests++;
        if (remaining !== 4'd6) begin
            n_fail++;
            $display("FAIL areset_base_default: got %0d expected 6", remaining);
        end
        wait_exp(40, n);
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        start_code(2'b10);
        wait_exp(20, n);
        n_tests++;
        if (n < 7 || n > 9) begin
            n_fail++;
            $display("FAIL b2b_first_latency: got %0d cycles expected 8 +/- 1", n);
        end
        start_code(2'b01);
        n_tests++;
        if (expired !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_cycle: got exp=%b busy=%b expected exp=0 busy=0", expired, busy);
        end
        tick();
        n_tests++;
        if (remaining !== 4'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pending_load: got rem=%0d busy=%b expected rem=3 busy=1",
                     remaining, busy);
        end
        wait_exp(40, n);
        n_tests++;
        if (n < 11 || n > 13) begin
            n_fail++;
            $display("FAIL b2b_second_latency: got %0d cycles expected 12 +/- 1", n);
        end
        tick();
    endtask

`ifdef TIMER_PAUSE_EN
    task automatic test_pause();
        int n_ref, n_tail, hz;
        logic [CNT_W-1:0] held;
        logic moved;
        program_reg(2'b10, 4'd3);
        start_code(2'b10);
        wait_exp(40, n_ref);
        n_tests++;
        if (n_ref < 11 || n_ref > 13) begin
            n_fail++;
            $display("FAIL pause_ref_latency: got %0d cycles expected 12 +/- 1", n_ref);
        end
        tick();
        start_code(2'b10);
        tick();
        tick();
        tick();
        pause = 1'b1;
        held  = remaining;
        hz    = 0;
        moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #0;
            if (one_hz) hz++;
            tick();
            if (remaining != held) moved = 1'b1;
        end
        pause = 1'b0;
        n_tests++;
        if (hz != 0 || moved !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_freeze: got hz=%0d moved=%b busy=%b expected 0 0 1", hz, moved, busy);
        end
        wait_exp(60, n_tail);
        n_tests++;
        if (n_tail < 0 || (n_tail + 13) != (n_ref + 10)) begin
            n_fail++;
            $display("FAIL pause_delay: got %0d cycles expected %0d", n_tail + 13, n_ref + 10);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_base_default();
        test_tzero();
        test_programming();
        test_restart();
        test_collision();
        test_async_reset();
        test_back_to_back();
`ifdef TIMER_PAUSE_EN
        test_pause();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
